// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: strobes one column at a time, debounces a single key
// press/release and presents the accepted key as registered one-hot row/column.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_drv,
    output logic       R1,
    output logic       R2,
    output logic       R3,
    output logic       R4,
    output logic       C1,
    output logic       C2,
    output logic       C3,
    output logic       C4,
    output logic       key_valid
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    state_t        state_q,    state_d;
    logic [3:0]    row_meta_q, row_meta_d;
    logic [3:0]    row_sync_q, row_sync_d;
    logic [DW-1:0] dwell_q,    dwell_d;
    logic [1:0]    col_idx_q,  col_idx_d;
    logic [3:0]    cand_row_q, cand_row_d;
    logic [CW-1:0] stable_q,   stable_d;
    logic [CW-1:0] release_q,  release_d;
    logic [3:0]    row_out_q,  row_out_d;
    logic [3:0]    col_out_q,  col_out_d;
    logic          key_valid_q, key_valid_d;

    logic          sample;
    logic          row_one_hot;
    logic [3:0]    col_one_hot;
    logic [CW-1:0] stable_inc;
    logic [CW-1:0] release_inc;

    assign sample      = (dwell_q == DWELL_MAX);
    assign row_one_hot = (row_sync_q != 4'd0) && ((row_sync_q & (row_sync_q - 4'd1)) == 4'd0);
    assign col_one_hot = 4'b0001 << col_idx_q;
    assign stable_inc  = stable_q + CNT_ONE;
    assign release_inc = release_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        row_meta_d  = row_in;
        row_sync_d  = row_meta_q;
        dwell_d     = sample ? '0 : dwell_q + DW'(1);
        col_idx_d   = col_idx_q;
        cand_row_d  = cand_row_q;
        stable_d    = stable_q;
        release_d   = release_q;
        row_out_d   = row_out_q;
        col_out_d   = col_out_q;
        key_valid_d = 1'b0;

        // Everything below only reacts on the sample cycle at the end of a dwell.
        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_one_hot) begin
                        cand_row_d = row_sync_q;
                        stable_d   = CNT_ONE;
                        if (DEB_MAX == CNT_ONE) begin
                            state_d     = ST_PRESSED;
                            row_out_d   = row_sync_q;
                            col_out_d   = col_one_hot;
                            key_valid_d = 1'b1;
                            release_d   = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end

                ST_DEBOUNCE: begin
                    if (row_sync_q == cand_row_q) begin
                        stable_d = stable_inc;
                        if (stable_inc == DEB_MAX) begin
                            state_d     = ST_PRESSED;
                            row_out_d   = cand_row_q;
                            col_out_d   = col_one_hot;
                            key_valid_d = 1'b1;
                            release_d   = '0;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                        stable_d  = '0;
                    end
                end

                ST_PRESSED: begin
                    // Extra or different keys only reset the release count.
                    if (row_sync_q == 4'd0) begin
                        if (release_inc == DEB_MAX) begin
                            state_d   = ST_SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                            row_out_d = 4'd0;
                            col_out_d = 4'd0;
                            release_d = '0;
                            stable_d  = '0;
                        end else begin
                            release_d = release_inc;
                        end
                    end else begin
                        release_d = '0;
                    end
                end

                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            row_meta_q  <= 4'd0;
            row_sync_q  <= 4'd0;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            cand_row_q  <= 4'd0;
            stable_q    <= '0;
            release_q   <= '0;
            row_out_q   <= 4'd0;
            col_out_q   <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            cand_row_q  <= cand_row_d;
            stable_q    <= stable_d;
            release_q   <= release_d;
            row_out_q   <= row_out_d;
            col_out_q   <= col_out_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_drv   = col_one_hot;
    assign R1        = row_out_q[0];
    assign R2        = row_out_q[1];
    assign R3        = row_out_q[2];
    assign R4        = row_out_q[3];
    assign C1        = col_out_q[0];
    assign C2        = col_out_q[1];
    assign C3        = col_out_q[2];
    assign C4        = col_out_q[3];
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2; a keypad model
// drives rows only while the pressed key's column is strobed.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_drv;
    logic       R1, R2, R3, R4, C1, C2, C3, C4;
    logic       key_valid;
    logic [7:0] rc;

    logic       key_a;
    logic [1:0] key_a_row;
    logic [1:0] key_a_col;
    logic       key_b;
    logic [1:0] key_b_row;
    logic [1:0] key_b_col;

    int         checks = 0;
    int         errors = 0;
    int         valid_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_drv  (col_drv),
        .R1       (R1),
        .R2       (R2),
        .R3       (R3),
        .R4       (R4),
        .C1       (C1),
        .C2       (C2),
        .C3       (C3),
        .C4       (C4),
        .key_valid(key_valid)
    );

    assign rc = {R1, R2, R3, R4, C1, C2, C3, C4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a held key connects its row only while its column is driven.
    always_comb begin
        row_in = 4'd0;
        if (key_a && col_drv[key_a_col]) row_in[key_a_row] = 1'b1;
        if (key_b && col_drv[key_b_col]) row_in[key_b_row] = 1'b1;
    end

    // Records every key_valid pulse together with the outputs presented with it.
    always @(negedge clk) begin
        if (key_valid) begin
            valid_count++;
            obs_q.push_back(rc);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic active, input logic [1:0] row, input logic [1:0] col);
        key_a     = active;
        key_a_row = row;
        key_a_col = col;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkScoreboard(input string tag);
        logic [7:0] e;
        logic [7:0] o;
        checks++;
        assert (obs_q.size() > 0 && exp_q.size() > 0)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d pulses queued expected %0d", tag, obs_q.size(), exp_q.size());
        end
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checkOutput(tag, 16'(o), 16'(e));
        end
    endtask

    task automatic waitValid(input int target, input int budget);
        int n = 0;
        while (valid_count < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("wait_valid_in_budget", 16'(valid_count >= target), 16'd1);
    endtask

    initial begin
        rst = 1'b1;
        key_b = 1'b0;
        key_b_row = 2'd0;
        key_b_col = 2'd0;
        applyStimulus(1'b0, 2'd0, 2'd0);

        // Reset state.
        tick(3);
        checkOutput("reset_col_drv", 16'(col_drv), 16'h1);
        checkOutput("reset_outputs", 16'(rc), 16'h0);
        checkOutput("reset_key_valid", 16'(key_valid), 16'h0);
        rst = 1'b0;

        // Idle scan: four cycles per column, full rotation in 16 cycles.
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] exp_col;
            tick(1);
            exp_col = 4'b0001 << ((i / 4) % 4);
            checkOutput($sformatf("idle_col_%0d", i), 16'(col_drv), 16'(exp_col));
        end
        checkOutput("idle_outputs", 16'(rc), 16'h0);
        checkOutput("idle_no_pulse", 16'(valid_count), 16'd0);

        // Key row 1 / column 1.
        applyStimulus(1'b1, 2'd0, 2'd0);
        exp_q.push_back(8'b1000_1000);
        tick(7);
        checkOutput("k11_before_accept", 16'(rc), 16'h0);
        checkOutput("k11_kv_before", 16'(key_valid), 16'h0);
        tick(1);
        checkOutput("k11_kv_pulse", 16'(key_valid), 16'h1);
        checkOutput("k11_outputs", 16'(rc), 16'h88);
        tick(1);
        checkOutput("k11_kv_single", 16'(key_valid), 16'h0);
        checkScoreboard("k11_scoreboard");
        tick(39);
        checkOutput("k11_held", 16'(rc), 16'h88);
        checkOutput("k11_col_frozen", 16'(col_drv), 16'h1);
        checkOutput("k11_one_pulse", 16'(valid_count), 16'd1);
        applyStimulus(1'b0, 2'd0, 2'd0);
        tick(7);
        checkOutput("k11_release_pending", 16'(rc), 16'h88);
        tick(1);
        checkOutput("k11_released", 16'(rc), 16'h0);
        checkOutput("k11_resume_col", 16'(col_drv), 16'h2);

        // Key row 4 / column 2.
        applyStimulus(1'b1, 2'd3, 2'd1);
        exp_q.push_back(8'b0001_0100);
        tick(7);
        checkOutput("k42_kv_before", 16'(key_valid), 16'h0);
        tick(1);
        checkOutput("k42_kv_pulse", 16'(key_valid), 16'h1);
        checkOutput("k42_outputs", 16'(rc), 16'h14);
        tick(1);
        checkScoreboard("k42_scoreboard");
        tick(7);
        applyStimulus(1'b0, 2'd0, 2'd0);
        tick(7);
        checkOutput("k42_release_pending", 16'(rc), 16'h14);
        tick(1);
        checkOutput("k42_released", 16'(rc), 16'h0);
        checkOutput("k42_resume_col", 16'(col_drv), 16'h4);

        // Bounce: row 2 on column 3 seen by one sample only.
        applyStimulus(1'b1, 2'd1, 2'd2);
        tick(4);
        applyStimulus(1'b0, 2'd0, 2'd0);
        tick(1);
        checkOutput("bounce_col_frozen", 16'(col_drv), 16'h4);
        tick(3);
        checkOutput("bounce_next_col", 16'(col_drv), 16'h8);
        checkOutput("bounce_outputs", 16'(rc), 16'h0);
        checkOutput("bounce_no_pulse", 16'(valid_count), 16'd2);

        // Rows 1 and 2 together on column 1 are ignored.
        applyStimulus(1'b1, 2'd0, 2'd0);
        key_b_row = 2'd1;
        key_b_col = 2'd0;
        key_b = 1'b1;
        tick(8);
        checkOutput("multi_col_advances", 16'(col_drv), 16'h2);
        checkOutput("multi_outputs", 16'(rc), 16'h0);
        applyStimulus(1'b0, 2'd0, 2'd0);
        key_b = 1'b0;
        tick(4);
        checkOutput("multi_no_pulse", 16'(valid_count), 16'd2);

        // Reset while PRESSED, then the held key is accepted again.
        applyStimulus(1'b1, 2'd0, 2'd0);
        exp_q.push_back(8'b1000_1000);
        waitValid(3, 64);
        tick(1);
        checkScoreboard("pre_reset_scoreboard");
        checkOutput("pre_reset_pressed", 16'(rc), 16'h88);
        tick(2);
        rst = 1'b1;
        tick(1);
        checkOutput("rst_outputs", 16'(rc), 16'h0);
        checkOutput("rst_key_valid", 16'(key_valid), 16'h0);
        checkOutput("rst_col_drv", 16'(col_drv), 16'h1);
        rst = 1'b0;
        exp_q.push_back(8'b1000_1000);
        tick(7);
        checkOutput("reaccept_before", 16'(rc), 16'h0);
        tick(1);
        checkOutput("reaccept_kv_pulse", 16'(key_valid), 16'h1);
        checkOutput("reaccept_outputs", 16'(rc), 16'h88);
        tick(1);
        checkScoreboard("reaccept_scoreboard");
        applyStimulus(1'b0, 2'd0, 2'd0);
        tick(6);
        checkOutput("reaccept_release_pending", 16'(rc), 16'h88);
        tick(1);
        checkOutput("reaccept_released", 16'(rc), 16'h0);
        checkOutput("reaccept_resume_col", 16'(col_drv), 16'h2);

        tick(4);
        checkOutput("pulse_total", 16'(valid_count), 16'd4);
        checkOutput("scoreboard_drained", 16'(obs_q.size() + exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_DIV, default 1000: clock cycles each column is driven before its rows are sampled; minimum 4.
REQ-002 DEBOUNCE, default 4: consecutive identical samples needed to accept a press or a release; minimum 1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 row_in  input  4  keypad row sense, active-high, asynchronous; row_in[0]=row 1 ... row_in[3]=row 4.
REQ-006 col_drv  output  4  one-hot column strobe; col_drv[0]=column 1 ... col_drv[3]=column 4.
REQ-007 R1,R2,R3,R4  output  1 each  registered one-hot row of the accepted key; all 0 when no key is accepted.
REQ-008 C1,C2,C3,C4  output  1 each  registered one-hot column of the accepted key; all 0 when no key is accepted.
REQ-009 key_valid  output  1  single-cycle pulse on acceptance of a new press.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-011 A dwell counter SHALL count 0..SCAN_DIV-1; a sample is taken on the cycle the count equals SCAN_DIV-1, then the count wraps to 0.
REQ-012 States SHALL be SCAN, DEBOUNCE, PRESSED.
REQ-013 SCAN: on each sample, col index advances (3 wraps to 0) and col_drv = one-hot(col index); R/C outputs stay 0.
REQ-014 SCAN: a sample with exactly one row bit set SHALL latch the candidate (row, col), set stable count to 1, and enter DEBOUNCE with the column frozen; if DEBOUNCE=1, enter PRESSED directly.
REQ-015 SCAN: a sample with zero rows, or with two or more rows set, SHALL be ignored and scanning continues.
REQ-016 DEBOUNCE: a sample equal to the candidate row one-hot SHALL increment the stable count; on reaching DEBOUNCE, enter PRESSED.
REQ-017 DEBOUNCE: any mismatching sample SHALL return to SCAN, with the column advancing to the next index.
REQ-018 Entering PRESSED SHALL, in the same clock edge, load R1..R4/C1..C4 with the candidate one-hot (R1 = row 1, C1 = column 1) and assert key_valid for exactly one cycle.
REQ-019 PRESSED: the column stays frozen and the outputs are held.
REQ-020 PRESSED: each all-zero sample increments a release count; any nonzero sample clears it.
REQ-021 PRESSED: when the release count reaches DEBOUNCE, R/C outputs SHALL clear to 0 and the block returns to SCAN, advancing to the next column.
REQ-022 Only one key_valid pulse SHALL occur per press, however long the press lasts.
REQ-023 Simultaneous or additional keys seen during PRESSED SHALL NOT change the outputs.
REQ-024 Candidate, stable count and release count SHALL be sized to DEBOUNCE; the dwell counter SHALL be sized to SCAN_DIV, and neither SHALL overflow.
REQ-025 Press latency: key_valid asserts DEBOUNCE-1 dwell periods after the first qualifying sample, on the clock after the final matching sample.

Reset
REQ-026 With rst high at a clock edge, the next state SHALL be: state SCAN, col index 0, col_drv=0001, dwell/stable/release counts 0, synchronizer 0, R1..R4 = C1..C4 = 0, key_valid 0.
REQ-027 Reset in any state, including mid-DEBOUNCE or PRESSED, SHALL take priority over every other event on that edge.

Verification (SCAN_DIV=4, DEBOUNCE=2; keypad model drives row_in for a pressed key only while its column is strobed)
REQ-028 Reset, no key -> col_drv=0001 for 4 cycles, then 0010, 0100, 1000, then back to 0001 after 16 cycles; all outputs 0; key_valid never high.
REQ-029 Hold key row 1/col 1 -> {R1..R4,C1..C4}=10001000, one key_valid pulse, held while pressed; after release, cleared 2 samples (8 cycles) later and scanning resumes at 0010.
REQ-030 Hold key row 4/col 2 -> outputs 00010100, one key_valid pulse.
REQ-031 Bounce: row 2 asserted for a single sample on col 3 -> no key_valid, outputs stay 0, next col_drv=1000.
REQ-032 Rows 1 and 2 asserted together on col 1 -> ignored, no key_valid, scanning continues.
REQ-033 rst pulsed while PRESSED -> one cycle later outputs all 0, key_valid 0, col_drv=0001; the still-held key is re-accepted with a fresh key_valid.
